led_shift_chain_driver: RTL and testbench
=========================================

// Module: led_shift_chain_driver
// PURPOSE
//  Parametrised serial LED driver feeding external shift-register/latch chains (74HC595-style).
//  Accepts a parallel word per chain over a valid/ready handshake, then drives all chains in lockstep.
//  Shifts every chain out serially on a shared divided shift clock, then pulses a shared latch.
//  Optional auto-refresh re-sends the last word continuously; sits between the CPU output port and the board LEDs.
// PARAMETERS
//  DATA_W       16  bits per chain per frame (>=2)
//  CHAINS       1   independent serial data lines sharing clock/latch (>=1)
//  CLK_DIV      4   i_CLK cycles per shift-clock half period, T (>=1)
//  MSB_FIRST    1   1: bit DATA_W-1 shifted first; 0: bit 0 first
//  AUTO_REFRESH 0   1: re-send held word whenever idle and no new word offered
// PORTS
//  i_CLK       in   1               system clock, all logic on rising edge
//  i_RESET_n   in   1               asynchronous active-low reset
//  i_Data      in   CHAINS*DATA_W   chain k word = i_Data[k*DATA_W +: DATA_W]
//  i_Valid     in   1               i_Data valid
//  o_Ready     out  1               driver idle, will accept on this cycle
//  o_LEDData   out  CHAINS          serial data, bit k drives chain k
//  o_LEDClk    out  1               shift clock, chains shift on rising edge
//  o_LEDLatch  out  1               storage latch strobe, active high
//  o_Busy      out  1               frame in progress (= !o_Ready)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, o_Ready=1, o_Busy=0, o_LEDData=0, o_LEDClk=0,
//   o_LEDLatch=0, held-word valid flag cleared. All outputs registered.
//  FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (next bit SHIFT_LO | last bit LATCH) -> IDLE.
//  Accept: i_Valid && o_Ready at edge n; word copied to shift reg and held reg; i_Data don't-care after.
//  SHIFT_LO: o_LEDClk=0, o_LEDData = current bit per chain, T cycles (setup).
//  SHIFT_HI: o_LEDClk=1, o_LEDData stable, T cycles; bit index advances on exit.
//  LATCH: o_LEDClk=0, o_LEDLatch=1, o_LEDData=0, T cycles.
//  Frame = (2*DATA_W+1)*T cycles after accept edge; o_Ready=0 throughout, 1 on following cycle.
//  IDLE outputs: o_LEDClk=0, o_LEDLatch=0, o_LEDData=0.
//  i_Valid while busy: ignored, no capture; source holds word until handshake.
//  AUTO_REFRESH=1: IDLE lasts exactly 1 cycle once held flag set; new i_Valid has priority,
//   else held word resent (o_Ready stays 1 in that cycle, refresh starts next edge).
//   Held flag 0 (post-reset, no word yet): no refresh, stay IDLE.
//  AUTO_REFRESH=0: stay IDLE until i_Valid.
//  Reset mid-frame: outputs drop to 0 immediately, no latch pulse; chain latches keep old image.
//  Divider counter 0..T-1, wraps, restarts at 0 on every state entry; T=1 gives fCLK/2 shift clock.
// STRUCTURE
//  Package led_driver_pkg: FSM state encoding (IDLE, SHIFT_LO, SHIFT_HI, LATCH), width helper for
//   bit counter ($clog2(DATA_W)) and divider counter ($clog2(CLK_DIV) min 1).
//  Sub-module led_bit_timer: CLK_DIV phase counter, clear-on-state-entry input, terminal-count output.
//  Top: FSM, bit counter, CHAINS shift registers (generate loop), held-word register, flag.
// TESTING
//  1 Defaults, reset then accept 16'h9D1F -> bits at o_LEDClk rises 1001_1101_0001_1111; latch high
//    cycles 129-132 after accept edge; o_Ready=1 at cycle 133.
//  2 MSB_FIRST=0, 16'h9D1F -> bit order 1111_1000_1011_1001; frame length unchanged (132).
//  3 CHAINS=2, i_Data={16'hA5A5,16'h0F0F} -> o_LEDData[0] carries 0F0F, [1] carries A5A5,
//    same clock edges, one latch pulse.
//  4 Hold i_Valid with 16'h1111 then change to 16'h2222 mid-frame -> only 1111 sent; 2222 accepted
//    on first o_Ready cycle, second frame starts next edge.
//  5 Deassert i_RESET_n during bit 7 SHIFT_HI -> all outputs 0 same time step, no latch pulse;
//    after release o_Ready=1 and (AUTO_REFRESH=1) no refresh frame until new i_Valid.
//  6 AUTO_REFRESH=1, accept 16'h1234 once -> back-to-back 1234 frames, 1 idle cycle between;
//    offer 16'hBEEF mid-frame -> BEEF sent from next frame onward, refreshed thereafter.

Source files
------------

// File: rtl/led_driver_pkg.sv
// Shared definitions for the serial LED shift-chain driver: FSM encoding and counter width helper.
package led_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } led_state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_shift_chain_driver_if.sv
// Parallel word handshake between the CPU output port and the LED chain driver.
interface led_shift_chain_driver_if #(
    parameter int CHAINS = 1,
    parameter int DATA_W = 16
);
    logic [CHAINS*DATA_W-1:0] data;
    logic                     valid;
    logic                     ready;
    logic                     busy;

    modport master (output data, valid, input ready, busy);
    modport slave  (input data, valid, output ready, busy);
endinterface

// File: rtl/led_bit_timer.sv
// Shift-clock phase divider: counts 0..CLK_DIV-1, restarts on every FSM state entry.
module led_bit_timer
    import led_driver_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_Clear,
    output logic o_TC
);
    localparam int CNT_W = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            cnt_q <= '0;
        end else if (i_Clear || o_TC) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_TC = (cnt_q == LAST);

endmodule

// File: rtl/led_shift_chain_driver.sv
// Serial driver for 74HC595-style chains: shifts one word per chain in lockstep, then pulses the latch.
module led_shift_chain_driver
    import led_driver_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CHAINS       = 1,
    parameter int CLK_DIV      = 4,
    parameter int MSB_FIRST    = 1,
    parameter int AUTO_REFRESH = 0
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET_n,
    led_shift_chain_driver_if.slave bus,
    output logic [CHAINS-1:0]       o_LEDData,
    output logic                    o_LEDClk,
    output logic                    o_LEDLatch
);
    localparam int BIT_W = cnt_w(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    led_state_e               state_q, state_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                     tc, load, use_new, shift;
    logic                     held_vld_q;
    logic [CHAINS*DATA_W-1:0] held_q;
    logic [CHAINS-1:0]        first_bit;

    led_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .i_CLK     (i_CLK),
        .i_RESET_n (i_RESET_n),
        .i_Clear   (state_d != state_q),
        .o_TC      (tc)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        use_new   = 1'b0;
        shift     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A fresh word always wins over re-sending the held one.
                if (bus.ready && bus.valid) begin
                    state_d   = ST_SHIFT_LO;
                    load      = 1'b1;
                    use_new   = 1'b1;
                    bit_cnt_d = '0;
                end else if ((AUTO_REFRESH != 0) && held_vld_q) begin
                    state_d   = ST_SHIFT_LO;
                    load      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT_LO: if (tc) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (tc) begin
                    shift = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d   = ST_SHIFT_LO;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_LATCH: if (tc) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < CHAINS; k++) begin : g_chain
        logic [DATA_W-1:0] sr_q, sr_d;

        always_comb begin
            sr_d = sr_q;
            if (load) begin
                sr_d = use_new ? bus.data[k*DATA_W +: DATA_W] : held_q[k*DATA_W +: DATA_W];
            end else if (shift) begin
                sr_d = (MSB_FIRST != 0) ? {sr_q[DATA_W-2:0], 1'b0} : {1'b0, sr_q[DATA_W-1:1]};
            end
        end

        always_ff @(posedge i_CLK) begin
            sr_q <= sr_d;
        end

        assign first_bit[k] = (MSB_FIRST != 0) ? sr_d[DATA_W-1] : sr_d[0];
    end

    always_ff @(posedge i_CLK) begin
        if (load && use_new) held_q <= bus.data;
    end

    // Outputs are registered from next-state so pins change on the same edge as the FSM.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            held_vld_q <= 1'b0;
            bus.ready  <= 1'b1;
            bus.busy   <= 1'b0;
            o_LEDData  <= '0;
            o_LEDClk   <= 1'b0;
            o_LEDLatch <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            if (load && use_new) held_vld_q <= 1'b1;
            bus.ready  <= (state_d == ST_IDLE);
            bus.busy   <= (state_d != ST_IDLE);
            o_LEDData  <= (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) ? first_bit : '0;
            o_LEDClk   <= (state_d == ST_SHIFT_HI);
            o_LEDLatch <= (state_d == ST_LATCH);
        end
    end

endmodule

// File: tb/tb_led_shift_chain_driver.sv
// Directed bench for led_shift_chain_driver across default, LSB-first, two-chain and auto-refresh builds.
module tb_led_shift_chain_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        tb_valid [4];
    logic [31:0] tb_data  [4];

    led_shift_chain_driver_if #(.CHAINS(1), .DATA_W(16)) if0 ();
    led_shift_chain_driver_if #(.CHAINS(1), .DATA_W(16)) if1 ();
    led_shift_chain_driver_if #(.CHAINS(2), .DATA_W(16)) if2 ();
    led_shift_chain_driver_if #(.CHAINS(1), .DATA_W(16)) if3 ();

    assign if0.valid = tb_valid[0];
    assign if0.data  = tb_data[0][15:0];
    assign if1.valid = tb_valid[1];
    assign if1.data  = tb_data[1][15:0];
    assign if2.valid = tb_valid[2];
    assign if2.data  = tb_data[2];
    assign if3.valid = tb_valid[3];
    assign if3.data  = tb_data[3][15:0];

    logic       led0_data, led1_data, led3_data;
    logic [1:0] led2_data;
    logic       led_clk [4];
    logic       led_lat [4];

    led_shift_chain_driver dut0 (
        .i_CLK(clk), .i_RESET_n(rst_n), .bus(if0),
        .o_LEDData(led0_data), .o_LEDClk(led_clk[0]), .o_LEDLatch(led_lat[0]));
    led_shift_chain_driver #(.MSB_FIRST(0)) dut1 (
        .i_CLK(clk), .i_RESET_n(rst_n), .bus(if1),
        .o_LEDData(led1_data), .o_LEDClk(led_clk[1]), .o_LEDLatch(led_lat[1]));
    led_shift_chain_driver #(.CHAINS(2)) dut2 (
        .i_CLK(clk), .i_RESET_n(rst_n), .bus(if2),
        .o_LEDData(led2_data), .o_LEDClk(led_clk[2]), .o_LEDLatch(led_lat[2]));
    led_shift_chain_driver #(.AUTO_REFRESH(1)) dut3 (
        .i_CLK(clk), .i_RESET_n(rst_n), .bus(if3),
        .o_LEDData(led3_data), .o_LEDClk(led_clk[3]), .o_LEDLatch(led_lat[3]));

    int         sel = 0;
    logic [1:0] obs_data;
    logic       obs_clk, obs_latch, obs_ready, obs_busy;

    always_comb begin
        obs_data  = '0;
        obs_clk   = 1'b0;
        obs_latch = 1'b0;
        obs_ready = 1'b0;
        obs_busy  = 1'b0;
        case (sel)
            0: begin obs_data = {1'b0, led0_data}; obs_clk = led_clk[0]; obs_latch = led_lat[0];
                     obs_ready = if0.ready; obs_busy = if0.busy; end
            1: begin obs_data = {1'b0, led1_data}; obs_clk = led_clk[1]; obs_latch = led_lat[1];
                     obs_ready = if1.ready; obs_busy = if1.busy; end
            2: begin obs_data = led2_data; obs_clk = led_clk[2]; obs_latch = led_lat[2];
                     obs_ready = if2.ready; obs_busy = if2.busy; end
            default: begin obs_data = {1'b0, led3_data}; obs_clk = led_clk[3]; obs_latch = led_lat[3];
                     obs_ready = if3.ready; obs_busy = if3.busy; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one word into the selected DUT; returns 1 time unit after the accept edge.
    task automatic offer(input int s, input logic [31:0] w);
        @(negedge clk);
        tb_valid[s] = 1'b1;
        tb_data[s]  = w;
        @(posedge clk);
        #1;
        tb_valid[s] = 1'b0;
    endtask

    // Called just after an accept edge: negedge number c falls inside cycle c of the frame.
    task automatic capture(input int chg_cyc, input logic [31:0] chg_data,
                           output logic [15:0] b0, output logic [15:0] b1,
                           output int rises, output int pulses,
                           output int lat_first, output int lat_last, output int ready_at);
        logic prev_clk, prev_lat;
        b0 = '0; b1 = '0; rises = 0; pulses = 0;
        lat_first = 0; lat_last = 0; ready_at = 0;
        prev_clk = 1'b0; prev_lat = 1'b0;
        for (int c = 1; c <= 200 && ready_at == 0; c++) begin
            @(negedge clk);
            if (c == chg_cyc) begin
                tb_valid[sel] = 1'b1;
                tb_data[sel]  = chg_data;
            end
            if (obs_clk && !prev_clk) begin
                rises++;
                b0 = {b0[14:0], obs_data[0]};
                b1 = {b1[14:0], obs_data[1]};
            end
            if (obs_latch) begin
                if (lat_first == 0) lat_first = c;
                lat_last = c;
                if (!prev_lat) pulses++;
            end
            if (obs_ready) ready_at = c;
            prev_clk = obs_clk;
            prev_lat = obs_latch;
        end
    endtask

    logic [15:0] b0, b1;
    int rises, pulses, lat_first, lat_last, ready_at, seen;

    initial begin
        for (int s = 0; s < 4; s++) begin
            tb_valid[s] = 1'b0;
            tb_data[s]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check("reset_ready", {31'd0, obs_ready}, 32'd1);
            check("reset_busy",  {31'd0, obs_busy},  32'd0);
            check("reset_outs",  {29'd0, obs_data, obs_clk | obs_latch}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Default build, MSB first
        sel = 0;
        offer(0, 32'h9D1F);
        check("t1_busy", {31'd0, obs_busy}, 32'd1);
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t1_bits", {16'd0, b0}, 32'h9D1F);
        check("t1_rises", rises, 16);
        check("t1_lat_first", lat_first, 129);
        check("t1_lat_last", lat_last, 132);
        check("t1_pulses", pulses, 1);
        check("t1_ready_at", ready_at, 133);

        // LSB first
        sel = 1;
        offer(1, 32'h9D1F);
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t2_bits", {16'd0, b0}, 32'hF8B9);
        check("t2_lat_last", lat_last, 132);
        check("t2_ready_at", ready_at, 133);

        // Two chains in lockstep
        sel = 2;
        offer(2, {16'hA5A5, 16'h0F0F});
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t3_chain0", {16'd0, b0}, 32'h0F0F);
        check("t3_chain1", {16'd0, b1}, 32'hA5A5);
        check("t3_rises", rises, 16);
        check("t3_pulses", pulses, 1);
        check("t3_ready_at", ready_at, 133);

        // Held valid; word changes mid-frame and must wait for the next handshake
        sel = 0;
        @(negedge clk);
        tb_valid[0] = 1'b1;
        tb_data[0]  = 32'h1111;
        @(posedge clk);
        #1;
        capture(50, 32'h2222, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t4_first_bits", {16'd0, b0}, 32'h1111);
        check("t4_first_ready", ready_at, 133);
        @(posedge clk);
        #1;
        tb_valid[0] = 1'b0;
        check("t4_second_busy", {31'd0, obs_busy}, 32'd1);
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t4_second_bits", {16'd0, b0}, 32'h2222);
        check("t4_second_ready", ready_at, 133);

        // Reset during bit 7 SHIFT_HI (cycles 61..64) on the auto-refresh build
        sel = 3;
        offer(3, 32'hFFFF);
        repeat (62) @(negedge clk);
        check("t5_in_hi_clk", {31'd0, obs_clk}, 32'd1);
        check("t5_in_hi_data", {30'd0, obs_data}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", {29'd0, obs_data, obs_clk}, 32'd0);
        check("t5_rst_latch", {31'd0, obs_latch}, 32'd0);
        check("t5_rst_ready", {31'd0, obs_ready}, 32'd1);
        check("t5_rst_busy", {31'd0, obs_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (obs_busy || obs_latch || obs_clk) seen++;
        end
        check("t5_no_refresh", seen, 0);
        check("t5_ready_after", {31'd0, obs_ready}, 32'd1);

        // Auto refresh: back-to-back frames with a single idle cycle, new word takes over
        offer(3, 32'h1234);
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t6_f1_bits", {16'd0, b0}, 32'h1234);
        check("t6_f1_ready", ready_at, 133);
        @(posedge clk);
        #1;
        check("t6_f2_busy", {31'd0, obs_busy}, 32'd1);
        capture(40, 32'hBEEF, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t6_f2_bits", {16'd0, b0}, 32'h1234);
        check("t6_f2_ready", ready_at, 133);
        @(posedge clk);
        #1;
        tb_valid[3] = 1'b0;
        check("t6_f3_busy", {31'd0, obs_busy}, 32'd1);
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t6_f3_bits", {16'd0, b0}, 32'hBEEF);
        check("t6_f3_pulses", pulses, 1);
        @(posedge clk);
        #1;
        check("t6_f4_busy", {31'd0, obs_busy}, 32'd1);
        capture(0, 32'h0, b0, b1, rises, pulses, lat_first, lat_last, ready_at);
        check("t6_f4_bits", {16'd0, b0}, 32'hBEEF);
        check("t6_f4_ready", ready_at, 133);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
